// File: rtl/diff_accum_pkg.sv
// Shared types and constants for the difference accumulator.
// Holds the FSM state enum, default widths and the sign-extension helper.
package diff_accum_pkg;

   localparam int SUB_W_DEF     = 5;
   localparam int ACC_W_DEF     = 8;
   localparam int FRAME_LEN_DEF = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Sign-extends the low w bits of v to 32 bits; callers truncate to their own width.
   function automatic logic [31:0] sext(input logic [31:0] v, input int w);
      logic signed [31:0] t;
      t = signed'(v << (32 - w));
      return t >>> (32 - w);
   endfunction

endpackage

// File: rtl/diff_accumulator_if.sv
// Handshake bundle for diff_accumulator: difference input stream and frame total output stream.
interface diff_accumulator_if #(
   parameter int SUB_W = 5,
   parameter int ACC_W = 8
);

   logic [SUB_W-1:0] subIn;
   logic             subValid;
   logic             subReady;
   logic [ACC_W-1:0] sumOut;
   logic             sumValid;
   logic             sumReady;
   logic             ovfOut;

   modport master (
      output subIn, subValid, sumReady,
      input  subReady, sumOut, sumValid, ovfOut
   );

   modport slave (
      input  subIn, subValid, sumReady,
      output subReady, sumOut, sumValid, ovfOut
   );

endinterface

// File: rtl/diff_accumulator_sat_add.sv
// Signed W-bit adder with overflow flag.
// Defining DIFF_ACCUM_SAT_EN clamps overflowing results; otherwise they wrap.
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W-1:0] raw;

   assign raw = a + b;
   assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef DIFF_ACCUM_SAT_EN
   // The sign of a tells which rail was crossed.
   always_comb begin
      sum = raw;
      if (ovf) begin
         sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   assign sum = raw;
`endif

endmodule

// File: rtl/diff_accumulator.sv
// Sums FRAME_LEN signed differences per frame and holds the total until taken.
// Saturating arithmetic is selected with DIFF_ACCUM_SAT_EN (default: wrap).
module diff_accumulator
   import diff_accum_pkg::*;
#(
   parameter int SUB_W     = SUB_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF
) (
   input logic             clk,
   input logic             rst,
   diff_accumulator_if.slave bus
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_t           state;
   state_t           stateNext;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] subExt;
   logic [ACC_W-1:0] addResult;
   logic [ACC_W-1:0] sumReg;
   logic [CNT_W-1:0] cnt;
   logic             addOvf;
   logic             ovfFrame;
   logic             ovfReg;
   logic             accept;
   logic             lastSample;
   logic             consume;

   assign subExt = ACC_W'(sext(32'(bus.subIn), SUB_W));

   sat_add #(.W(ACC_W)) u_sat_add (
      .a   (acc),
      .b   (subExt),
      .sum (addResult),
      .ovf (addOvf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= stateNext;
      end
   end

   // Handshake outputs are decoded straight from the registered state.
   always_comb begin
      stateNext    = state;
      accept       = 1'b0;
      lastSample   = 1'b0;
      consume      = 1'b0;
      bus.subReady = 1'b0;
      bus.sumValid = 1'b0;
      case (state)
         ACCUM: begin
            bus.subReady = 1'b1;
            accept       = bus.subValid;
            if (bus.subValid && (cnt == LAST_CNT)) begin
               lastSample = 1'b1;
               stateNext  = HOLD;
            end
         end
         HOLD: begin
            bus.sumValid = 1'b1;
            if (bus.sumReady) begin
               consume   = 1'b1;
               stateNext = ACCUM;
            end
         end
         default: stateNext = ACCUM;
      endcase
   end

   // ovfFrame remembers any overflow seen earlier in the current frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         sumReg   <= '0;
         ovfFrame <= 1'b0;
         ovfReg   <= 1'b0;
      end else if (accept) begin
         if (lastSample) begin
            sumReg   <= addResult;
            ovfReg   <= ovfFrame | addOvf;
            acc      <= '0;
            cnt      <= '0;
            ovfFrame <= 1'b0;
         end else begin
            acc      <= addResult;
            cnt      <= cnt + 1'b1;
            ovfFrame <= ovfFrame | addOvf;
         end
      end else if (consume) begin
         ovfReg <= 1'b0;
      end
   end

   assign bus.sumOut = sumReg;
   assign bus.ovfOut = ovfReg;

endmodule
